// File: rtl/owt_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : owt_rx_frame_ctrl
// Purpose  : Receive-side sequencer for the one-wire-transfer symbol measurer.
//            Drives the measurer count enable, classifies each measured symbol
//            length as SYNC / BIT0 / BIT1 / illegal, assembles FRAME_BITS data
//            bits after a SYNC and reports completed frames and errors.
// Ports    : i_clk       clock
//            i_rst_n     asynchronous active-low reset
//            i_rx_en     receiver enable (level)
//            i_sym_vld   measurer symbol-valid pulse
//            i_sym_len   measured symbol length (sampled with i_sym_vld)
//            o_cnt_flg   count enable to measurer
//            o_busy      high while collecting frame data
//            o_frm_vld   one-cycle frame-complete pulse
//            o_frm_data  last completed frame, MSB = first received bit
//            o_err       one-cycle error pulse
//            o_err_code  1 = sync in data, 2 = illegal length, 3 = timeout
// Revision : 1.0  initial release
// ============================================================================
module owt_rx_frame_ctrl #(
    parameter int CNT_OWT_EXT_CYC_W = 8,
    parameter int FRAME_BITS        = 16,
    parameter int BIT0_MIN          = 3,
    parameter int BIT0_MAX          = 5,
    parameter int BIT1_MIN          = 7,
    parameter int BIT1_MAX          = 9,
    parameter int SYNC_MIN          = 14,
    parameter int SYNC_MAX          = 18,
    parameter int TIMEOUT_CYC       = 40
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_rx_en,
    input  logic                         i_sym_vld,
    input  logic [CNT_OWT_EXT_CYC_W-1:0] i_sym_len,
    output logic                         o_cnt_flg,
    output logic                         o_busy,
    output logic                         o_frm_vld,
    output logic [FRAME_BITS-1:0]        o_frm_data,
    output logic                         o_err,
    output logic [1:0]                   o_err_code
);

    localparam int BCNT_W = $clog2(FRAME_BITS + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    typedef logic [CNT_OWT_EXT_CYC_W-1:0] len_t;
    typedef logic [BCNT_W-1:0]            bcnt_t;
    typedef logic [IDLE_W-1:0]            idle_t;

    localparam len_t  C_BIT0_MIN = len_t'(BIT0_MIN);
    localparam len_t  C_BIT0_MAX = len_t'(BIT0_MAX);
    localparam len_t  C_BIT1_MIN = len_t'(BIT1_MIN);
    localparam len_t  C_BIT1_MAX = len_t'(BIT1_MAX);
    localparam len_t  C_SYNC_MIN = len_t'(SYNC_MIN);
    localparam len_t  C_SYNC_MAX = len_t'(SYNC_MAX);
    localparam bcnt_t C_FRAME_BITS  = bcnt_t'(FRAME_BITS);
    localparam idle_t C_TIMEOUT_CYC = idle_t'(TIMEOUT_CYC);

    localparam logic [1:0] C_ERR_SYNC = 2'd1;
    localparam logic [1:0] C_ERR_LEN  = 2'd2;
    localparam logic [1:0] C_ERR_TO   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_HUNT    = 3'd2,
        S_DATA    = 3'd3,
        S_RESTART = 3'd4
    } state_t;

    state_t                state_q, state_d;
    bcnt_t                 bcnt_q, bcnt_d;
    idle_t                 idle_q, idle_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [FRAME_BITS-1:0] frm_data_q, frm_data_d;
    logic                  frm_vld_q, frm_vld_d;
    logic                  err_q, err_d;
    logic [1:0]            err_code_q, err_code_d;
    logic                  cnt_flg_q, busy_q;

    // Classification with SYNC > BIT1 > BIT0 priority.
    logic  w_is_sync, w_is_bit1, w_is_bit0;
    bcnt_t w_bcnt_inc;
    idle_t w_idle_inc;
    logic  w_cnt_flg_d;

    assign w_is_sync = (i_sym_len >= C_SYNC_MIN) && (i_sym_len <= C_SYNC_MAX);
    assign w_is_bit1 = !w_is_sync && (i_sym_len >= C_BIT1_MIN) && (i_sym_len <= C_BIT1_MAX);
    assign w_is_bit0 = !w_is_sync && !w_is_bit1 &&
                       (i_sym_len >= C_BIT0_MIN) && (i_sym_len <= C_BIT0_MAX);

    assign w_bcnt_inc = bcnt_q + 1'b1;
    // Saturating idle counter increment.
    assign w_idle_inc = (idle_q == '1) ? idle_q : idle_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        bcnt_d     = bcnt_q;
        idle_d     = idle_q;
        shift_d    = shift_q;
        frm_data_d = frm_data_q;
        frm_vld_d  = 1'b0;
        err_d      = 1'b0;
        err_code_d = err_code_q;

        case (state_q)
            S_IDLE: begin
                if (i_rx_en) state_d = S_ARM;
            end
            S_ARM: begin
                // First symbol measures from an arbitrary start point.
                if (i_sym_vld) state_d = S_HUNT;
            end
            S_HUNT: begin
                if (i_sym_vld && w_is_sync) begin
                    state_d = S_DATA;
                    bcnt_d  = '0;
                    shift_d = '0;
                    idle_d  = '0;
                end
            end
            S_DATA: begin
                if (i_sym_vld) begin
                    // A symbol in the terminal-count cycle wins over timeout.
                    idle_d = '0;
                    if (w_is_sync) begin
                        err_d      = 1'b1;
                        err_code_d = C_ERR_SYNC;
                        bcnt_d     = '0;
                        shift_d    = '0;
                    end else if (w_is_bit1 || w_is_bit0) begin
                        shift_d = {shift_q[FRAME_BITS-2:0], w_is_bit1};
                        bcnt_d  = w_bcnt_inc;
                        if (w_bcnt_inc == C_FRAME_BITS) begin
                            frm_data_d = {shift_q[FRAME_BITS-2:0], w_is_bit1};
                            frm_vld_d  = 1'b1;
                            state_d    = S_RESTART;
                        end
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = C_ERR_LEN;
                        state_d    = S_RESTART;
                    end
                end else begin
                    idle_d = w_idle_inc;
                    if (w_idle_inc == C_TIMEOUT_CYC) begin
                        err_d      = 1'b1;
                        err_code_d = C_ERR_TO;
                        state_d    = S_RESTART;
                    end
                end
            end
            S_RESTART: begin
                state_d = S_ARM;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Disable drops any partial frame silently and overrides everything.
        if (!i_rx_en) begin
            state_d    = S_IDLE;
            frm_vld_d  = 1'b0;
            frm_data_d = frm_data_q;
            err_d      = 1'b0;
            err_code_d = err_code_q;
        end
    end

    // Count enable is registered from the next state so it changes on the
    // same edge that enters ARM, RESTART or IDLE.
    assign w_cnt_flg_d = (state_d == S_ARM) || (state_d == S_HUNT) || (state_d == S_DATA);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            bcnt_q     <= '0;
            idle_q     <= '0;
            shift_q    <= '0;
            frm_data_q <= '0;
            frm_vld_q  <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'd0;
            cnt_flg_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bcnt_q     <= bcnt_d;
            idle_q     <= idle_d;
            shift_q    <= shift_d;
            frm_data_q <= frm_data_d;
            frm_vld_q  <= frm_vld_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            cnt_flg_q  <= w_cnt_flg_d;
            busy_q     <= (state_d == S_DATA);
        end
    end

    assign o_cnt_flg  = cnt_flg_q;
    assign o_busy     = busy_q;
    assign o_frm_vld  = frm_vld_q;
    assign o_frm_data = frm_data_q;
    assign o_err      = err_q;
    assign o_err_code = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_owt_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_owt_rx_frame_ctrl
// Purpose  : Self-checking bench for owt_rx_frame_ctrl. Expected frame/error
//            pulses (kind, payload, cycle) are queued as stimulus is driven
//            and compared by a monitor whenever the DUT pulses.
// Revision : 1.0  initial release
// ============================================================================
module tb_owt_rx_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_en = 1'b0;
    logic        sym_vld = 1'b0;
    logic [7:0]  sym_len = 8'd0;
    logic        o_cnt_flg, o_busy, o_frm_vld, o_err;
    logic [15:0] o_frm_data;
    logic [1:0]  o_err_code;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        bit          is_err;
        logic [15:0] val;
        int          cyc;
    } ev_t;

    ev_t sb[$];
    ev_t mon_ev;

    owt_rx_frame_ctrl dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_rx_en    (rx_en),
        .i_sym_vld  (sym_vld),
        .i_sym_len  (sym_len),
        .o_cnt_flg  (o_cnt_flg),
        .o_busy     (o_busy),
        .o_frm_vld  (o_frm_vld),
        .o_frm_data (o_frm_data),
        .o_err      (o_err),
        .o_err_code (o_err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Scoreboard monitor: every pulse must match the head of the queue.
    always @(negedge clk) begin
        if (rst_n && (o_frm_vld || o_err)) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse frm_vld=%0b err=%0b code=%0d data=%h cyc=%0d",
                         o_frm_vld, o_err, o_err_code, o_frm_data, cyc);
            end else begin
                mon_ev = sb.pop_front();
                if (mon_ev.is_err) begin
                    if (o_err !== 1'b1 || o_frm_vld !== 1'b0 ||
                        o_err_code !== mon_ev.val[1:0] || cyc != mon_ev.cyc) begin
                        bad++;
                        $display("FAIL err_pulse got err=%0b vld=%0b code=%0d cyc=%0d want code=%0d cyc=%0d",
                                 o_err, o_frm_vld, o_err_code, cyc, mon_ev.val[1:0], mon_ev.cyc);
                    end
                end else begin
                    if (o_frm_vld !== 1'b1 || o_err !== 1'b0 ||
                        o_frm_data !== mon_ev.val || cyc != mon_ev.cyc) begin
                        bad++;
                        $display("FAIL frame_pulse got vld=%0b err=%0b data=%h cyc=%0d want data=%h cyc=%0d",
                                 o_frm_vld, o_err, o_frm_data, cyc, mon_ev.val, mon_ev.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- helpers
    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Drives one symbol in the current cycle; returns that cycle index.
    task automatic sym(input logic [7:0] len, output int c);
        c       = cyc;
        sym_vld = 1'b1;
        sym_len = len;
        @(posedge clk);
        #1;
        sym_vld = 1'b0;
    endtask

    // Sends d[n-1:0] MSB first on consecutive cycles (1 -> len 8, 0 -> len 4).
    task automatic send_bits(input logic [15:0] d, input int n, output int last);
        int c;
        c = 0;
        for (int i = n - 1; i >= 0; i--) sym(d[i] ? 8'd8 : 8'd4, c);
        last = c;
    endtask

    task automatic push_frame(input logic [15:0] d, input int c);
        ev_t e;
        e.is_err = 1'b0; e.val = d; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic push_err(input logic [1:0] code, input int c);
        ev_t e;
        e.is_err = 1'b1; e.val = {14'd0, code}; e.cyc = c;
        sb.push_back(e);
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({o_cnt_flg, o_busy, o_frm_vld, o_err} !== 4'b0000 ||
            o_frm_data !== 16'h0000 || o_err_code !== 2'd0) begin
            bad++;
            $display("FAIL reset_values got flg=%0b busy=%0b vld=%0b err=%0b data=%h code=%0d want all 0",
                     o_cnt_flg, o_busy, o_frm_vld, o_err, o_frm_data, o_err_code);
        end
        rst_n = 1'b1;
        align();
    endtask

    task automatic test_frame();
        int c, l;
        rx_en = 1'b1;
        align();
        @(negedge clk);
        total++;
        if (o_cnt_flg !== 1'b1 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL arm_flags got flg=%0b busy=%0b want 1 0", o_cnt_flg, o_busy);
        end
        align();
        sym(8'd5, c);
        sym(8'd16, c);
        send_bits(16'hA5C3, 16, l);
        push_frame(16'hA5C3, l + 1);
        @(negedge clk);
        total++;
        if (o_cnt_flg !== 1'b0 || o_frm_data !== 16'hA5C3 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL restart_after_frame got flg=%0b data=%h busy=%0b want 0 a5c3 0",
                     o_cnt_flg, o_frm_data, o_busy);
        end
        @(negedge clk);
        total++;
        if (o_cnt_flg !== 1'b1) begin
            bad++;
            $display("FAIL rearm_flag got %0b want 1", o_cnt_flg);
        end
        align();
    endtask

    task automatic test_illegal();
        int c, l;
        sym(8'd5, c);
        sym(8'd16, c);
        send_bits(16'h0015, 5, l);
        sym(8'd12, c);
        push_err(2'd2, c + 1);
        @(negedge clk);
        total++;
        if (o_cnt_flg !== 1'b0 || o_err_code !== 2'd2) begin
            bad++;
            $display("FAIL illegal_restart got flg=%0b code=%0d want 0 2", o_cnt_flg, o_err_code);
        end
        @(negedge clk);
        total++;
        if (o_cnt_flg !== 1'b1) begin
            bad++;
            $display("FAIL illegal_rearm got flg=%0b want 1", o_cnt_flg);
        end
        align();
        // First symbol after ARM is discarded even if it looks like SYNC.
        sym(8'd16, c);
        @(negedge clk);
        total++;
        if (o_busy !== 1'b0) begin
            bad++;
            $display("FAIL arm_discard got busy=%0b want 0", o_busy);
        end
        align();
        sym(8'd16, c);
        @(negedge clk);
        total++;
        if (o_busy !== 1'b1) begin
            bad++;
            $display("FAIL hunt_sync got busy=%0b want 1", o_busy);
        end
        align();
    endtask

    task automatic test_resync();
        int c, l;
        send_bits(16'h0005, 3, l);
        sym(8'd14, c);
        push_err(2'd1, c + 1);
        @(negedge clk);
        total++;
        if (o_busy !== 1'b1 || o_err_code !== 2'd1) begin
            bad++;
            $display("FAIL resync_stay got busy=%0b code=%0d want 1 1", o_busy, o_err_code);
        end
        align();
        send_bits(16'h0001, 16, l);
        push_frame(16'h0001, l + 1);
        @(negedge clk);
        align();
        align();
    endtask

    task automatic test_timeout();
        int c, c1;
        sym(8'd5, c);
        sym(8'd16, c);
        push_err(2'd3, c + 41);
        repeat (40) align();
        @(negedge clk);
        total++;
        if (o_cnt_flg !== 1'b0 || o_err_code !== 2'd3 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL timeout_restart got flg=%0b code=%0d busy=%0b want 0 3 0",
                     o_cnt_flg, o_err_code, o_busy);
        end
        align();
        // Symbol arriving exactly at terminal count must win over the timeout.
        sym(8'd5, c);
        sym(8'd16, c1);
        repeat (39) align();
        sym(8'd4, c);
        @(negedge clk);
        total++;
        if (o_busy !== 1'b1 || o_cnt_flg !== 1'b1 || c != c1 + 40) begin
            bad++;
            $display("FAIL timeout_vld_wins got busy=%0b flg=%0b gap=%0d want 1 1 40",
                     o_busy, o_cnt_flg, c - c1);
        end
        align();
    endtask

    task automatic test_rx_drop();
        int c, l;
        send_bits(16'h01AB, 9, l);
        rx_en = 1'b0;
        sym(8'd8, c);
        @(negedge clk);
        total++;
        if (o_cnt_flg !== 1'b0 || o_busy !== 1'b0 || o_frm_data !== 16'h0001 ||
            o_err_code !== 2'd3) begin
            bad++;
            $display("FAIL rx_drop got flg=%0b busy=%0b data=%h code=%0d want 0 0 0001 3",
                     o_cnt_flg, o_busy, o_frm_data, o_err_code);
        end
        repeat (3) align();
        @(negedge clk);
        total++;
        if (o_cnt_flg !== 1'b0) begin
            bad++;
            $display("FAIL idle_hold got flg=%0b want 0", o_cnt_flg);
        end
        rx_en = 1'b1;
        align();
        align();
        sym(8'd5, c);
        sym(8'd16, c);
        send_bits(16'hFFFF, 16, l);
        push_frame(16'hFFFF, l + 1);
        @(negedge clk);
        total++;
        if (o_frm_data !== 16'hFFFF) begin
            bad++;
            $display("FAIL reenable_frame got %h want ffff", o_frm_data);
        end
        align();
        align();
    endtask

    task automatic test_async_reset();
        int c, l;
        sym(8'd5, c);
        sym(8'd16, c);
        send_bits(16'h0016, 5, l);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({o_cnt_flg, o_busy, o_frm_vld, o_err} !== 4'b0000 ||
            o_frm_data !== 16'h0000 || o_err_code !== 2'd0) begin
            bad++;
            $display("FAIL async_reset got flg=%0b busy=%0b vld=%0b err=%0b data=%h code=%0d want all 0",
                     o_cnt_flg, o_busy, o_frm_vld, o_err, o_frm_data, o_err_code);
        end
        align();
        rst_n = 1'b1;
        repeat (3) align();
    endtask

    initial begin
        test_reset();
        test_frame();
        test_illegal();
        test_resync();
        test_timeout();
        test_rx_drop();
        test_async_reset();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL missing_pulses got pending=%0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
